// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 definitions: transmitter states, command bytes, frame builder
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        TX,
        WAIT_ACK,
        WAIT_IDLE,
        ERR
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_ACK          = 8'hFA;

    // Bits after the start bit, LSB first: data, odd parity, stop
    function automatic logic [9:0] ps2_tx_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command request/status bundle between a PS/2 host controller and the transmitter
interface ps2_host_tx_if;

    logic       send_cmd;
    logic [7:0] the_command;
    logic       busy;
    logic       command_was_sent;
    logic       error_communication_timed_out;

    modport master (
        output send_cmd,
        output the_command,
        input  busy,
        input  command_was_sent,
        input  error_communication_timed_out
    );

    modport slave (
        input  send_cmd,
        input  the_command,
        output busy,
        output command_was_sent,
        output error_communication_timed_out
    );

endinterface

// File: rtl/ps2_edge_sync.sv
// rtl/ps2_edge_sync.sv - two-flop synchronizer for a raw PS/2 pin with a falling-edge pulse
module ps2_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to the idle-high line level so leaving reset never looks like an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= pin;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter; PS2_TX_RETRY_EN adds automatic retries
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
`ifdef PS2_TX_RETRY_EN
    ,
    parameter int RETRY_MAX = 1
`endif
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    ps2_host_tx_if.slave  cmd,
    input  logic          ps2_clk_in,
    input  logic          ps2_dat_in,
    output logic          ps2_clk_oe,
    output logic          ps2_dat_oe
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t state_q;
    ps2_tx_state_t state_d;

    logic          clk_level;
    logic          clk_fall;
    logic          dat_level;
    logic          dat_fall_unused;

    logic [7:0]    cmd_q;
    logic [9:0]    shift_q;
    logic [3:0]    bit_cnt;
    logic          dat_drv;
    logic [IW-1:0] inh_cnt;
    logic [WW-1:0] wdog;
    logic          wd_active;
    logic          wd_expire;
    logic          retry_ok;

    ps2_edge_sync u_clk_sync (
        .clk   (CLOCK_50),
        .reset (reset),
        .pin   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_edge_sync u_dat_sync (
        .clk   (CLOCK_50),
        .reset (reset),
        .pin   (ps2_dat_in),
        .level (dat_level),
        .fall  (dat_fall_unused)
    );

    assign wd_active = (state_q == TX) || (state_q == WAIT_ACK) || (state_q == WAIT_IDLE);
    assign wd_expire = wd_active && (wdog == WD_LAST);

`ifdef PS2_TX_RETRY_EN
    localparam int RW = (RETRY_MAX > 1) ? $clog2(RETRY_MAX + 1) : 1;

    logic [RW-1:0] retries_done;

    assign retry_ok = (int'(retries_done) < RETRY_MAX);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            retries_done <= '0;
        end else if (state_q == IDLE && cmd.send_cmd) begin
            retries_done <= '0;
        end else if (state_q == ERR && retry_ok) begin
            retries_done <= retries_done + 1'b1;
        end
    end
`else
    assign retry_ok = 1'b0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The watchdog is checked before any edge so a late edge cannot rescue an expired frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (cmd.send_cmd) state_d = INHIBIT;
            INHIBIT:   if (inh_cnt == INH_LAST) state_d = START;
            START:     state_d = TX;
            TX: begin
                if (wd_expire)                          state_d = ERR;
                else if (clk_fall && bit_cnt == 4'd9)   state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (wd_expire)     state_d = ERR;
                else if (clk_fall) state_d = dat_level ? ERR : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (wd_expire)                   state_d = ERR;
                else if (clk_level && dat_level) state_d = IDLE;
            end
            ERR:       state_d = retry_ok ? INHIBIT : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // The frame is rebuilt from the latched byte in START so a retry resends it unchanged
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cmd_q   <= '0;
            shift_q <= '0;
            bit_cnt <= '0;
            dat_drv <= 1'b0;
            inh_cnt <= '0;
            wdog    <= '0;
        end else begin
            inh_cnt <= (state_q == INHIBIT && inh_cnt != INH_LAST) ? inh_cnt + 1'b1 : '0;
            wdog    <= (wd_active && !clk_fall && !wd_expire) ? wdog + 1'b1 : '0;
            case (state_q)
                IDLE: begin
                    if (cmd.send_cmd) begin
                        cmd_q   <= cmd.the_command;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    shift_q <= ps2_tx_frame(cmd_q);
                    dat_drv <= 1'b1;
                    bit_cnt <= '0;
                end
                TX: begin
                    if (clk_fall && !wd_expire) begin
                        dat_drv <= ~shift_q[0];
                        shift_q <= {1'b0, shift_q[9:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ps2_clk_oe                        = (state_q == INHIBIT) || (state_q == START);
        ps2_dat_oe                        = (state_q == START) || (state_q == TX && dat_drv);
        cmd.busy                          = (state_q != IDLE);
        cmd.command_was_sent              = (state_q == WAIT_IDLE) && !wd_expire && clk_level && dat_level;
        cmd.error_communication_timed_out = (state_q == ERR) && !retry_ok;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 command transmitter. Sends one 8-bit command (e.g. 0xFF reset, 0xED LEDs, 0xF4 enable) to the keyboard or mouse.
- Sits beside the scan-code receiver on the same PS2_CLK/PS2_DAT lines.
- The top level wraps the open-drain outputs: PS2_CLK = ps2_clk_oe ? 0 : Z, and likewise for PS2_DAT.
- While busy is high, the top level masks the receiver's received_data_en.

Parameters:
- INHIBIT_CYCLES, 6000: number of CLOCK_50 cycles CLK is held low before a request (120 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: watchdog limit in cycles without a device clock edge (15 ms).
- RETRY_MAX, 1: number of automatic retries. Only used with PS2_TX_RETRY_EN.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- send_cmd  in  1  one-cycle request. Accepted only in IDLE.
- the_command  in  8  command byte. Sampled on an accepted send_cmd.
- ps2_clk_in  in  1  raw PS2_CLK pin, asynchronous.
- ps2_dat_in  in  1  raw PS2_DAT pin, asynchronous.
- ps2_clk_oe  out  1  1 = pull CLK low.
- ps2_dat_oe  out  1  1 = pull DAT low.
- busy  out  1  high from the cycle after acceptance until return to IDLE.
- command_was_sent  out  1  one-cycle pulse on ACK completion.
- error_communication_timed_out  out  1  one-cycle pulse on timeout or missing ACK.

Behaviour:
- Reset values: all outputs 0. State = IDLE. Bit counter 0. Watchdog 0.
- Reset mid-operation: both oe deassert at the next clock edge. No pulse is emitted.
- Input sync: two-flop synchronizer on each pin input.
- Falling edge detect: synchronized prev = 1 and current = 0, one cycle late. All protocol logic uses synchronized values.
- Parity: odd, i.e. ~^the_command.
- Shift register: 10 bits = {stop 1, parity, data[7:0]}. LSB is sent first.
- IDLE: oe = 0. If send_cmd is high, latch the byte, clear the counter, go to INHIBIT. busy = 1 from the next cycle. send_cmd while busy is ignored, not queued.
- INHIBIT: clk_oe = 1 for exactly INHIBIT_CYCLES cycles, then go to START.
- START: clk_oe = 1 and dat_oe = 1 for 1 cycle (start bit), then go to TX.
  - In TX, clk_oe = 0 and dat_oe stays 1.
  - Clear the watchdog.
- TX: on each detected falling edge k (k = 1..10), dat_oe = ~shift[k-1].
  - Edge 10 drives the stop bit, so dat_oe = 0.
  - After edge 10, go to WAIT_ACK.
- WAIT_ACK: on the next falling edge, sample DAT.
  - DAT = 0: go to WAIT_IDLE.
  - DAT = 1: go to ERR (no ACK).
- WAIT_IDLE: when sync CLK = 1 and DAT = 1 in the same cycle, pulse command_was_sent and go to IDLE.
- ERR: both oe = 0. Pulse error_communication_timed_out for 1 cycle. Go to IDLE.
- Watchdog:
  - Counts in TX, WAIT_ACK and WAIT_IDLE.
  - Cleared on every detected falling edge.
  - Reaching TIMEOUT_CYCLES-1 goes to ERR.
  - It takes priority over an edge arriving in the same cycle.
- Edges during IDLE, INHIBIT and START are ignored.
- Counter widths: $clog2 of the respective parameter. No wrap is possible because states exit at the limit.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined: on ERR, if retries_done < RETRY_MAX, increment retries_done and go to INHIBIT with the latched byte. No error pulse is emitted. busy stays high. The error pulses only after the final failure. retries_done clears on acceptance.
- Undefined: no retry logic and no retries_done register. ERR always pulses and returns to IDLE.

Decomposition:
- Shared package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, START, TX, WAIT_ACK, WAIT_IDLE, ERR);
  - command constants PS2_CMD_RESET = 8'hFF, PS2_CMD_SET_LEDS = 8'hED, PS2_CMD_ENABLE = 8'hF4;
  - PS2_ACK = 8'hFA.
- One natural sub-module, ps2_edge_sync: two-flop synchronizer plus falling-edge pulse. The receiver can reuse it.

Test Plan:
- Send 0xF4 with a device model clocking at ~12.5 kHz.
  - clk_oe is low for exactly 6000 cycles.
  - Device samples on rising edges: start 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - Device ACKs, then one command_was_sent pulse. busy = 0 afterwards.
- Send 0xED. Parity bit sampled = 1. Send 0x00. Parity bit sampled = 1. Send 0xFF. Parity bit sampled = 1.
- Device never clocks after release.
  - error_communication_timed_out pulses exactly 750000 cycles after START exit.
  - Both oe = 0 afterwards.
- Device clocks but holds DAT high at the ACK edge. Result: error pulse, no command_was_sent.
- send_cmd = 0xAA asserted while busy with 0xF4. Only 0xF4 appears on the wire.
- reset asserted mid-TX (after edge 4): oe = 0 next cycle, no pulses, a fresh send works. With PS2_TX_RETRY_EN: first attempt times out, second is ACKed, giving 2 inhibit phases, 1 sent pulse and 0 error pulses.
